// File: rtl/rv32i_run_ctrl.sv
// Run controller for the rv32i core: sequences core reset, supplies the boot PC,
// counts RUN cycles and retired instructions, and latches the end-of-program result.
module rv32i_run_ctrl #(
  parameter int unsigned XLEN       = 32,
  parameter logic [XLEN-1:0] PC_INIT = '0,
  parameter int unsigned RST_CYCLES = 3,
  parameter int unsigned MAX_CYCLES = 100000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [XLEN-1:0]  instr_i,
  input  logic             instr_valid_i,
  input  logic [XLEN-1:0]  a0_i,
  output logic             core_rst_o,
  output logic [XLEN-1:0]  pc_init_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [1:0]       cause_o,
  output logic [XLEN-1:0]  result_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instret_cnt_o
);

  localparam logic [1:0] S_HOLD    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_HALT    = 2'd2;
  localparam logic [1:0] S_TIMEOUT = 2'd3;

  localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WD_LAST   = CNT_W'(MAX_CYCLES - 1);

  localparam logic [XLEN-1:0] ECALL_ENC  = XLEN'(32'h0000_0073);
  localparam logic [XLEN-1:0] EBREAK_ENC = XLEN'(32'h0010_0073);

  logic [1:0]        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              is_ecall;
  logic              is_ebreak;
  logic              wd_hit;

  assign is_ecall   = instr_valid_i && (instr_i == ECALL_ENC);
  assign is_ebreak  = instr_valid_i && (instr_i == EBREAK_ENC);
  assign wd_hit     = (MAX_CYCLES != 0) && (cycle_cnt_o == WD_LAST);

  assign core_rst_o = (state != S_RUN);
  assign pc_init_o  = PC_INIT;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_HOLD;
      hold_cnt      <= '0;
      done_o        <= 1'b0;
      pass_o        <= 1'b0;
      cause_o       <= 2'd0;
      result_o      <= '0;
      cycle_cnt_o   <= '0;
      instret_cnt_o <= '0;
    end else begin
      case (state)
        S_HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) state <= S_RUN;
        end
        S_RUN: begin
          if (instr_valid_i && (instret_cnt_o != '1))
            instret_cnt_o <= instret_cnt_o + 1'b1;
          // A halting instruction wins over the watchdog; the timeout edge leaves
          // cycle_cnt at MAX_CYCLES-1 while a halt edge still counts its cycle.
          if (is_ecall || is_ebreak) begin
            state       <= S_HALT;
            done_o      <= 1'b1;
            cause_o     <= is_ecall ? 2'd1 : 2'd2;
            result_o    <= a0_i;
            pass_o      <= is_ecall && (a0_i == '0);
            cycle_cnt_o <= cycle_cnt_o + 1'b1;
          end else if (wd_hit) begin
            state    <= S_TIMEOUT;
            done_o   <= 1'b1;
            cause_o  <= 2'd3;
            pass_o   <= 1'b0;
            result_o <= '0;
          end else begin
            cycle_cnt_o <= cycle_cnt_o + 1'b1;
          end
        end
        default: begin
          // HALT and TIMEOUT are terminal: everything holds until rst_i.
        end
      endcase
    end
  end

endmodule

// File: doc/rv32i_run_ctrl.md
Name: rv32i_run_ctrl

Overview:
- Synthesizable run controller for the rv32i core: sequences core reset, supplies the boot PC, counts cycles and retired instructions, and detects end-of-program.
- Detects ECALL, EBREAK and a watchdog timeout, and latches the pass/fail result from a0.
- Sits between the top-level clock/reset and the core.
- Serves both simulation and FPGA builds, so the bench only waits on done_o.

Parameters:
- XLEN, 32, data/instruction width.
- PC_INIT, 32'h0, boot PC driven on pc_init_o.
- RST_CYCLES, 3, cycles core reset stays asserted after rst_i falls; legal range >= 1.
- MAX_CYCLES, 100000, watchdog limit in RUN cycles; 0 disables the watchdog.
- CNT_W, 32, width of the cycle and instret counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- instr_i  in  XLEN  instruction currently retiring
- instr_valid_i  in  1  instr_i retires this cycle
- a0_i  in  XLEN  current value of register x10
- core_rst_o  out  1  reset to core, active-high
- pc_init_o  out  XLEN  boot PC, constant PC_INIT
- done_o  out  1  program finished (sticky)
- pass_o  out  1  valid when done_o=1
- cause_o  out  2  0=none, 1=ECALL, 2=EBREAK, 3=TIMEOUT
- result_o  out  XLEN  a0 latched at halt
- cycle_cnt_o  out  CNT_W  RUN cycles elapsed
- instret_cnt_o  out  CNT_W  instructions retired

Behaviour:
- Single clock; reset is synchronous and active-high, named clk_i / rst_i. All state updates on posedge clk_i.
- Reset values while rst_i=1:
  - state=HOLD, hold_cnt=0, core_rst_o=1.
  - done_o=0, pass_o=0, cause_o=0, result_o=0.
  - cycle_cnt_o=0, instret_cnt_o=0.
  - pc_init_o=PC_INIT at all times.
- rst_i=1 in any state, including mid-run or halted, returns to HOLD with the reset values on the next edge.
- HOLD:
  - Each edge with rst_i=0 increments hold_cnt.
  - When hold_cnt==RST_CYCLES-1, move to RUN. core_rst_o is therefore low starting the RST_CYCLES-th cycle after rst_i falls.
  - Inputs are ignored in HOLD.
- RUN (core_rst_o=0):
  - cycle_cnt increments every cycle and wraps.
  - instret increments when instr_valid_i=1 and saturates at all-ones.
  - Halt decode applies only when instr_valid_i=1:
    - instr_i==32'h00000073 (ECALL) -> HALT, cause=1, result_o<=a0_i, pass_o<=(a0_i==0).
    - instr_i==32'h00100073 (EBREAK) -> HALT, cause=2, result_o<=a0_i, pass_o<=0.
  - The halting instruction is counted in instret. cycle_cnt includes the halt cycle.
  - Watchdog: if MAX_CYCLES!=0 and cycle_cnt==MAX_CYCLES-1 with no halt this cycle -> TIMEOUT, cause=3, pass_o=0, result_o=0.
  - ECALL/EBREAK on the same cycle as the watchdog limit: the halt wins.
- HALT / TIMEOUT (terminal):
  - done_o=1, core_rst_o=1 to freeze the core.
  - Counters, cause, result and pass are held.
  - Only rst_i exits.
- done_o, cause_o, pass_o and result_o are registered and change on the transition edge. Latency is 1 cycle from the sampled instruction to done_o.
- Other SYSTEM encodings (CSR ops, MRET, nonzero rd/rs1 with opcode 0x73) do not halt.

Test Plan:
- Reset sequencing: rst_i=1 for 2 cycles, then 0. Required: core_rst_o=1 for exactly 3 further edges, then 0; cycle_cnt_o starts at 0.
- ECALL pass: retire 5 valid NOPs (32'h00000013), then ECALL with a0_i=0. Required: next cycle done_o=1, cause_o=1, pass_o=1, result_o=0, instret_cnt_o=6, core_rst_o=1; all outputs held for 10 more cycles.
- EBREAK and ECALL fail: ECALL with a0_i=32'h0000002A -> pass_o=0, result_o=32'h2A. A fresh run with EBREAK -> cause_o=2, pass_o=0.
- Watchdog, with MAX_CYCLES=20 and no halt instruction: done_o rises after cycle_cnt_o reaches 19, with cause_o=3 and cycle_cnt_o=19 frozen. Separately, ECALL exactly at cycle_cnt=19 -> cause_o=1. With MAX_CYCLES=0, no timeout occurs within 1000 cycles.
- Gating and decode: ECALL pattern with instr_valid_i=0 -> no halt, instret unchanged. instr_i=32'h30200073 (MRET) valid -> no halt.
- Reset mid-operation: rst_i=1 during RUN at cycle 7, and separately during HALT. Required: next edge all outputs at reset values, then a full 3-cycle reset hold and a new count from 0.
